jtlabrun_prio: RTL and testbench
================================

// Module: jtlabrun_prio
// PURPOSE
//  Layer priority mixer feeding the colour mixer (007593 equivalent). Takes per-pixel
//  indices from the scroll layer, fix/text layer and object layer, resolves transparency
//  and priority, outputs the 7-bit palette index gfx_pxl plus delay-matched blanking.
//  CPU control register is double-buffered; the active copy updates only at vblank start.
// PARAMETERS
//  PIPE_DLY  2     pixel-clock stages from input pixels to gfx_pxl (fixed; checked by assertion)
//  BG_RST    3'd0  reset value of background palette bank (ctrl[6:4])
// PORTS
//  rst        in   1  asynchronous reset, active high
//  clk        in   1  system clock
//  pxl_cen    in   1  pixel clock enable
//  LHBL       in   1  horizontal blank, active low
//  LVBL       in   1  vertical blank, active low
//  LHBL_dly   out  1  LHBL delayed PIPE_DLY pxl_cen
//  LVBL_dly   out  1  LVBL delayed PIPE_DLY pxl_cen
//  prio_cs    in   1  CPU chip select, control register
//  cpu_cen    in   1  CPU clock enable
//  cpu_rnw    in   1  CPU read/not-write
//  cpu_dout   in   8  CPU write data
//  prio_dout  out  8  read-back of pending control register
//  scr_pxl    in   7  scroll layer {pal[2:0],idx[3:0]}
//  txt_pxl    in   7  fix layer    {pal[2:0],idx[3:0]}
//  obj_pxl    in   7  object layer {pal[2:0],idx[3:0]}
//  obj_prio   in   1  object pixel behind opaque scroll when 1
//  gfx_pxl    out  7  resolved palette index to colour mixer
// BEHAVIOUR
//  - Control reg bits: [0] scr_over_obj, [1] scr_en, [2] obj_en, [3] txt_en,
//    [6:4] background bank, [7] reserved (stored, read back, no effect).
//  - Write: cpu_cen & ~cpu_rnw & prio_cs -> pending <= cpu_dout on that clk.
//  - Active <= pending on the clk where a falling LVBL edge is detected (LVBL sampled
//    on pxl_cen). Write on the same clk as the edge: active takes cpu_dout (bypass).
//  - Reset: pending = active = {1'b0,BG_RST,4'b1110}; gfx_pxl=0; LHBL_dly=LVBL_dly=0.
//  - Opaque: idx[3:0] != 0 and layer enabled.
//  - Stage 1 (pxl_cen): register the three pixels, obj_prio, opaque flags, blanking.
//  - Stage 2 (pxl_cen): select, highest priority first:
//      txt opaque -> txt_pxl
//      obj opaque & ~obj_prio & ~scr_over_obj -> obj_pxl
//      scr opaque -> scr_pxl
//      obj opaque -> obj_pxl
//      else -> {bg_bank,4'h0}
//    If stage-1 LHBL or LVBL low: gfx_pxl <= 0.
//  - Latency exactly 2 pxl_cen edges for pixel and blanking; no update without pxl_cen.
//  - Between pxl_cen pulses all outputs hold.
//  - Reset mid-line: pipeline cleared, output 0 until two pxl_cen after release.
// STRUCTURE
//  - Package jtlabrun_prio_pkg: ctrl bit-position localparams, CTRL_RST, PXL_W=7.
//  - One sub-module natural: jtlabrun_prio_sel (combinational priority select), instanced
//    between stage-1 and stage-2 registers. Control double-buffer and blank delay inline.
// TESTING
//  1 Reset, scr=7'h15 txt=0 obj=0, LHBL=LVBL=1 -> gfx_pxl=0x15 after 2nd pxl_cen, not 1st.
//  2 txt=7'h21, obj=7'h32, scr=7'h15 -> 0x21; txt=7'h20 -> 0x32 (obj_prio=0, bit0=0).
//  3 Write ctrl=0x0F mid-frame -> output stays obj 0x32 until LVBL falls, then scr 0x15;
//    prio_dout=0x0F immediately after write.
//  4 ctrl=0x50 (all layers off, bank 5) -> gfx_pxl=0x50 for any inputs.
//  5 obj_prio=1, scr=7'h15, obj=7'h32 -> 0x15; scr=7'h10 -> 0x32.
//  6 LHBL low for 3 pxl_cen -> gfx_pxl=0 and LHBL_dly low for exactly 3 pxl_cen, 2 late;
//    assert rst mid-line -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/jtlabrun_prio_pkg.sv
// Shared constants for the layer priority mixer.
// Control register bit positions, reset value and pixel width.
package jtlabrun_prio_pkg;

  localparam int PXL_W    = 7;
  localparam int CTRL_SOO = 0;
  localparam int CTRL_SCR = 1;
  localparam int CTRL_OBJ = 2;
  localparam int CTRL_TXT = 3;
  localparam int CTRL_BG  = 4;

  localparam logic [7:0] CTRL_RST = 8'h0E;

  function automatic logic opaque(
    input logic [3:0] idx,
    input logic       en
  );
    return en & (|idx);
  endfunction

endpackage

// File: rtl/jtlabrun_prio_sel.sv
// Combinational layer select between the two pixel stages.
// Text wins, then object/scroll ordering, then the background bank.
module jtlabrun_prio_sel
  import jtlabrun_prio_pkg::*;
(
  input  logic [PXL_W-1:0] scr,
  input  logic [PXL_W-1:0] txt,
  input  logic [PXL_W-1:0] obj,
  input  logic             scr_op,
  input  logic             txt_op,
  input  logic             obj_op,
  input  logic             obj_prio,
  input  logic             scr_over_obj,
  input  logic [2:0]       bank,
  output logic [PXL_W-1:0] pxl
);

  always_comb begin
    pxl = {bank, 4'h0};
    if (txt_op)
      pxl = txt;
    else if (obj_op && !obj_prio && !scr_over_obj)
      pxl = obj;
    else if (scr_op)
      pxl = scr;
    else if (obj_op)
      pxl = obj;
  end

endmodule

// File: rtl/jtlabrun_prio.sv
// Layer priority mixer: two pxl_cen stages, double-buffered
// control register that goes live at the start of vblank.
module jtlabrun_prio
  import jtlabrun_prio_pkg::*;
#(
  parameter int         PIPE_DLY = 2,
  parameter logic [2:0] BG_RST   = 3'd0
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             pxl_cen,
  input  logic             LHBL,
  input  logic             LVBL,
  output logic             LHBL_dly,
  output logic             LVBL_dly,
  input  logic             prio_cs,
  input  logic             cpu_cen,
  input  logic             cpu_rnw,
  input  logic [7:0]       cpu_dout,
  output logic [7:0]       prio_dout,
  input  logic [PXL_W-1:0] scr_pxl,
  input  logic [PXL_W-1:0] txt_pxl,
  input  logic [PXL_W-1:0] obj_pxl,
  input  logic             obj_prio,
  output logic [PXL_W-1:0] gfx_pxl
);

  localparam logic [7:0] RST_VAL =
    {CTRL_RST[7], BG_RST, CTRL_RST[3:0]};

  a_pipe_dly: assert property (
    @(posedge clk) PIPE_DLY == 2);

  logic [7:0] pend;
  logic [6:0] act;
  logic       vb_last;
  logic       wr;
  logic       vb_fall;

  assign wr      = cpu_cen & ~cpu_rnw & prio_cs;
  assign vb_fall = pxl_cen & vb_last & ~LVBL;

  // A write landing on the vblank edge goes straight to the live copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend    <= RST_VAL;
      act     <= RST_VAL[6:0];
      vb_last <= 1'b0;
    end else begin
      if (wr) pend <= cpu_dout;
      if (pxl_cen) vb_last <= LVBL;
      if (vb_fall) act <= wr ? cpu_dout[6:0] : pend[6:0];
    end
  end

  assign prio_dout = pend;

  logic [PXL_W-1:0] s1_scr;
  logic [PXL_W-1:0] s1_txt;
  logic [PXL_W-1:0] s1_obj;
  logic             s1_oprio;
  logic             s1_scr_op;
  logic             s1_txt_op;
  logic             s1_obj_op;
  logic             s1_hb;
  logic             s1_vb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_scr    <= '0;
      s1_txt    <= '0;
      s1_obj    <= '0;
      s1_oprio  <= 1'b0;
      s1_scr_op <= 1'b0;
      s1_txt_op <= 1'b0;
      s1_obj_op <= 1'b0;
      s1_hb     <= 1'b0;
      s1_vb     <= 1'b0;
    end else if (pxl_cen) begin
      s1_scr    <= scr_pxl;
      s1_txt    <= txt_pxl;
      s1_obj    <= obj_pxl;
      s1_oprio  <= obj_prio;
      s1_scr_op <= opaque(scr_pxl[3:0], act[CTRL_SCR]);
      s1_txt_op <= opaque(txt_pxl[3:0], act[CTRL_TXT]);
      s1_obj_op <= opaque(obj_pxl[3:0], act[CTRL_OBJ]);
      s1_hb     <= LHBL;
      s1_vb     <= LVBL;
    end
  end

  logic [PXL_W-1:0] sel_pxl;

  jtlabrun_prio_sel u_sel (
    .scr          (s1_scr),
    .txt          (s1_txt),
    .obj          (s1_obj),
    .scr_op       (s1_scr_op),
    .txt_op       (s1_txt_op),
    .obj_op       (s1_obj_op),
    .obj_prio     (s1_oprio),
    .scr_over_obj (act[CTRL_SOO]),
    .bank         (act[CTRL_BG +: 3]),
    .pxl          (sel_pxl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gfx_pxl  <= '0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
    end else if (pxl_cen) begin
      gfx_pxl  <= (s1_hb & s1_vb) ? sel_pxl : '0;
      LHBL_dly <= s1_hb;
      LVBL_dly <= s1_vb;
    end
  end

endmodule

// File: tb/tb_jtlabrun_prio.sv
// Scoreboard bench for jtlabrun_prio: driver pushes expected
// pixels per pxl_cen, monitor checks them one pxl_cen later.
module tb_jtlabrun_prio;

  logic       rst;
  logic       clk;
  logic       pxl_cen;
  logic       LHBL;
  logic       LVBL;
  logic       LHBL_dly;
  logic       LVBL_dly;
  logic       prio_cs;
  logic       cpu_cen;
  logic       cpu_rnw;
  logic [7:0] cpu_dout;
  logic [7:0] prio_dout;
  logic [6:0] scr_pxl;
  logic [6:0] txt_pxl;
  logic [6:0] obj_pxl;
  logic       obj_prio;
  logic [6:0] gfx_pxl;

  jtlabrun_prio dut (
    .rst       (rst),
    .clk       (clk),
    .pxl_cen   (pxl_cen),
    .LHBL      (LHBL),
    .LVBL      (LVBL),
    .LHBL_dly  (LHBL_dly),
    .LVBL_dly  (LVBL_dly),
    .prio_cs   (prio_cs),
    .cpu_cen   (cpu_cen),
    .cpu_rnw   (cpu_rnw),
    .cpu_dout  (cpu_dout),
    .prio_dout (prio_dout),
    .scr_pxl   (scr_pxl),
    .txt_pxl   (txt_pxl),
    .obj_pxl   (obj_pxl),
    .obj_prio  (obj_prio),
    .gfx_pxl   (gfx_pxl)
  );

  typedef struct {
    int         tag;
    logic       chk;
    logic [6:0] pxl;
    logic       hb;
    logic       vb;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   drv_n  = 0;
  int   mon_n  = 0;
  logic cen_q  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic chk_eq(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cen_q = pxl_cen;

  always @(negedge clk) begin
    exp_t e;
    if (cen_q) begin
      mon_n++;
      while (q.size() > 0 && q[0].tag < mon_n - 2)
        void'(q.pop_front());
      if (q.size() > 0 && q[0].tag == mon_n - 2) begin
        e = q.pop_front();
        if (e.chk) begin
          chk_eq($sformatf("pxl#%0d", e.tag), {1'b0, gfx_pxl}, {1'b0, e.pxl});
          chk_eq($sformatf("hb#%0d", e.tag), {7'd0, LHBL_dly}, {7'd0, e.hb});
          chk_eq($sformatf("vb#%0d", e.tag), {7'd0, LVBL_dly}, {7'd0, e.vb});
        end
      end
    end
  end

  task automatic step(input logic [6:0] s, input logic [6:0] t,
                      input logic [6:0] o, input logic op,
                      input logic hb, input logic vb,
                      input logic [6:0] e, input logic chk = 1'b1,
                      input logic wr = 1'b0, input logic [7:0] wd = 8'h00);
    scr_pxl  = s;
    txt_pxl  = t;
    obj_pxl  = o;
    obj_prio = op;
    LHBL     = hb;
    LVBL     = vb;
    if (wr) begin
      prio_cs  = 1'b1;
      cpu_cen  = 1'b1;
      cpu_rnw  = 1'b0;
      cpu_dout = wd;
    end
    pxl_cen = 1'b1;
    @(posedge clk);
    q.push_back('{drv_n, chk, e, hb, vb});
    drv_n++;
    #1;
    pxl_cen = 1'b0;
    prio_cs = 1'b0;
    cpu_cen = 1'b0;
    cpu_rnw = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_ctrl(input logic [7:0] d);
    prio_cs  = 1'b1;
    cpu_cen  = 1'b1;
    cpu_rnw  = 1'b0;
    cpu_dout = d;
    @(posedge clk);
    #1;
    prio_cs = 1'b0;
    cpu_cen = 1'b0;
    cpu_rnw = 1'b1;
  endtask

  initial begin
    int left;
    rst = 1'b1;
    pxl_cen = 1'b0;
    LHBL = 1'b1;
    LVBL = 1'b1;
    prio_cs = 1'b0;
    cpu_cen = 1'b0;
    cpu_rnw = 1'b1;
    cpu_dout = 8'h00;
    scr_pxl = 7'h15;
    txt_pxl = 7'h00;
    obj_pxl = 7'h00;
    obj_prio = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_gfx", {1'b0, gfx_pxl}, 8'h00);
    chk_eq("rst_hb", {7'd0, LHBL_dly}, 8'h00);
    chk_eq("rst_vb", {7'd0, LVBL_dly}, 8'h00);
    chk_eq("rst_ctrl", prio_dout, 8'h0E);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: two-stage latency
    step(7'h15, 7'h00, 7'h00, 1'b0, 1'b1, 1'b1, 7'h15);
    chk_eq("lat_1st", {1'b0, gfx_pxl}, 8'h00);
    step(7'h15, 7'h00, 7'h00, 1'b0, 1'b1, 1'b1, 7'h15);

    // 2: txt over obj over scr
    step(7'h15, 7'h21, 7'h32, 1'b0, 1'b1, 1'b1, 7'h21);
    step(7'h15, 7'h20, 7'h32, 1'b0, 1'b1, 1'b1, 7'h32);

    // 3: pending write, live at vblank
    wr_ctrl(8'h0F);
    chk_eq("rd_0f", prio_dout, 8'h0F);
    step(7'h15, 7'h00, 7'h32, 1'b0, 1'b1, 1'b1, 7'h32);
    step(7'h15, 7'h00, 7'h32, 1'b0, 1'b1, 1'b1, 7'h32);
    step(7'h15, 7'h00, 7'h32, 1'b0, 1'b1, 1'b0, 7'h00);
    step(7'h15, 7'h00, 7'h32, 1'b0, 1'b1, 1'b0, 7'h00);
    step(7'h15, 7'h00, 7'h32, 1'b0, 1'b1, 1'b1, 7'h15);
    step(7'h15, 7'h00, 7'h32, 1'b0, 1'b1, 1'b1, 7'h15);

    // 4: all layers off, bank 5
    wr_ctrl(8'h50);
    step(7'h15, 7'h21, 7'h32, 1'b0, 1'b1, 1'b1, 7'h21);
    step(7'h15, 7'h21, 7'h32, 1'b0, 1'b1, 1'b0, 7'h00);
    step(7'h15, 7'h21, 7'h32, 1'b0, 1'b1, 1'b1, 7'h50);
    step(7'h7F, 7'h7F, 7'h7F, 1'b1, 1'b1, 1'b1, 7'h50);

    // 5: bypass write on the vblank edge, then obj_prio
    step(7'h15, 7'h00, 7'h32, 1'b1, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 8'h0E);
    chk_eq("rd_0e", prio_dout, 8'h0E);
    step(7'h15, 7'h00, 7'h32, 1'b1, 1'b1, 1'b1, 7'h15);
    step(7'h10, 7'h00, 7'h32, 1'b1, 1'b1, 1'b1, 7'h32);
    step(7'h15, 7'h00, 7'h32, 1'b0, 1'b1, 1'b1, 7'h32);

    // 6: hblank window, then async reset
    step(7'h15, 7'h00, 7'h00, 1'b0, 1'b1, 1'b1, 7'h15);
    step(7'h15, 7'h00, 7'h00, 1'b0, 1'b0, 1'b1, 7'h00);
    step(7'h15, 7'h00, 7'h00, 1'b0, 1'b0, 1'b1, 7'h00);
    step(7'h15, 7'h00, 7'h00, 1'b0, 1'b0, 1'b1, 7'h00);
    step(7'h15, 7'h00, 7'h00, 1'b0, 1'b1, 1'b1, 7'h15);
    step(7'h15, 7'h00, 7'h00, 1'b0, 1'b1, 1'b1, 7'h15);
    wr_ctrl(8'h8E);
    chk_eq("rd_8e", prio_dout, 8'h8E);
    #2;
    rst = 1'b1;
    #1;
    chk_eq("arst_gfx", {1'b0, gfx_pxl}, 8'h00);
    chk_eq("arst_hb", {7'd0, LHBL_dly}, 8'h00);
    chk_eq("arst_vb", {7'd0, LVBL_dly}, 8'h00);
    chk_eq("arst_ctrl", prio_dout, 8'h0E);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step(7'h15, 7'h00, 7'h00, 1'b0, 1'b1, 1'b1, 7'h15);
    chk_eq("post_rst", {1'b0, gfx_pxl}, 8'h00);
    step(7'h15, 7'h00, 7'h00, 1'b0, 1'b1, 1'b1, 7'h15);

    step(7'h00, 7'h00, 7'h00, 1'b0, 1'b1, 1'b1, 7'h00, 1'b0);
    step(7'h00, 7'h00, 7'h00, 1'b0, 1'b1, 1'b1, 7'h00, 1'b0);
    left = 0;
    foreach (q[i]) if (q[i].chk) left++;
    chk_eq("drain", left[7:0], 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
